// File: rtl/mprj_io_arb_pkg.sv
`default_nettype none
// mprj_io_arb_pkg: shared types and bank-mapping constants for the user IO pad arbiter.
// Rev 1.0
package mprj_io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    // Wrapper pad numbers covered by the shared bank, high to low.
    localparam int BANK_HI_MSB  = 37;
    localparam int BANK_HI_LSB  = 30;
    localparam int BANK_MID_MSB = 15;
    localparam int BANK_MID_LSB = 8;
    localparam int BANK_LO_MSB  = 7;
    localparam int BANK_LO_LSB  = 0;

    localparam int DEFAULT_PADS = (BANK_HI_MSB - BANK_HI_LSB + 1)
                                + (BANK_MID_MSB - BANK_MID_LSB + 1)
                                + (BANK_LO_MSB - BANK_LO_LSB + 1);

    function automatic int onehot_idx(input logic [7:0] vec);
        int idx;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// rr_pick: combinational round-robin selector, first request at or above ptr, wrapping.
// Rev 1.0
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         winner,
    output logic                    valid
);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mprj_io_arbiter.sv
`default_nettype none
// mprj_io_arbiter: round-robin time-sharing of the 24-pad user IO bank with hold timeout
// and a forced high-Z turnaround between owners.  Rev 1.0
module mprj_io_arbiter
    import mprj_io_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int PADS     = DEFAULT_PADS,
    parameter int TURN_CYC = 2,
    parameter int HOLD_MAX = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*PADS-1:0] req_out_i,
    input  logic [NREQ*PADS-1:0] req_oeb_i,
    output logic [NREQ-1:0]      grant_o,
    output logic [PADS-1:0]      io_out,
    output logic [PADS-1:0]      io_oeb,
    output logic [2:0]           irq
);

    localparam int PW = $clog2(NREQ);
    localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam int TW = $clog2(TURN_CYC + 1);

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [HW-1:0]   hold;
    logic [TW-1:0]   turn;

    logic [NREQ-1:0] pick_onehot;
    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   next_ptr;
    logic [PW-1:0]   sel_idx;
    logic [PADS-1:0] sel_out;
    logic [PADS-1:0] sel_oeb;
    logic [HW-1:0]   hold_inc;
    logic            owner_req;
    logic            others_req;
    logic            timeout;
    logic            last_turn;
    logic            grant_now;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req    (req_i),
        .ptr    (ptr),
        .winner (pick_onehot),
        .valid  (pick_valid)
    );

    assign pick_idx = PW'(onehot_idx(8'(pick_onehot)));
    assign next_ptr = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

    // Pad data comes from the incoming owner on a grant edge, else the sitting owner.
    assign sel_idx = (state == OWN) ? owner : pick_idx;
    assign sel_out = req_out_i[int'(sel_idx)*PADS +: PADS];
    assign sel_oeb = req_oeb_i[int'(sel_idx)*PADS +: PADS];

    // Counter value after this cycle's increment; timeout fires on the HOLD_MAX-th OWN cycle.
    assign hold_inc   = (hold == HW'(HOLD_MAX)) ? hold : hold + 1'b1;
    assign timeout    = (HOLD_MAX != 0) && (hold_inc == HW'(HOLD_MAX));
    assign owner_req  = req_i[owner];
    assign others_req = |(req_i & ~grant_o);
    assign last_turn  = (turn == TW'(TURN_CYC - 1));
    assign grant_now  = pick_valid && ((state == IDLE) || ((state == TURN) && last_turn));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            hold    <= '0;
            turn    <= '0;
            grant_o <= '0;
            io_out  <= '0;
            io_oeb  <= '1;
            irq     <= '0;
        end else begin
            irq <= '0;
            if (grant_now) begin
                state   <= OWN;
                owner   <= pick_idx;
                ptr     <= next_ptr;
                hold    <= '0;
                grant_o <= pick_onehot;
                io_out  <= sel_out;
                io_oeb  <= sel_oeb;
                irq[1]  <= 1'b1;
            end else begin
                case (state)
                    OWN: begin
                        if (!owner_req || (timeout && others_req)) begin
                            state   <= TURN;
                            turn    <= '0;
                            grant_o <= '0;
                            io_out  <= '0;
                            io_oeb  <= '1;
                            // A voluntary release in the timeout cycle is not a preemption.
                            irq[0]  <= owner_req;
                        end else begin
                            hold   <= hold_inc;
                            io_out <= sel_out;
                            io_oeb <= sel_oeb;
                        end
                    end
                    TURN: begin
                        if (last_turn) state <= IDLE;
                        else           turn  <= turn + 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
